// File: rtl/uart_tx.sv
// UART transmitter: start bit, 5-8 data bits LSB first, optional parity, 1-2 stop bits.
// Bit timing comes from the 16x oversample tick; the frame start is gated by cts_n.
module uart_tx #(
  parameter int TICKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_tick,
  input  logic [1:0]  data_bit_num_i,
  input  logic        parity_en_i,
  input  logic        parity_type_i,
  input  logic        stop_bit_num_i,
  input  logic [31:0] tx_data_i,
  input  logic        start_tx_i,
  input  logic        cts_n,
  output logic        tx,
  output logic        tx_busy_o,
  output logic        tx_done_o,
  output logic        tx_enable
);

  localparam int CW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TICK_MAX = CW'(TICKS_PER_BIT - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} state_t;

  state_t          state_reg;
  logic [CW-1:0]   tick_cnt_reg;
  logic [2:0]      bit_idx_reg;
  logic            stop_cnt_reg;
  logic [7:0]      data_reg;
  logic [1:0]      data_bit_num_reg;
  logic            parity_en_reg;
  logic            parity_reg;
  logic            stop_bit_num_reg;
  logic            tx_reg;
  logic            busy_reg;
  logic            done_reg;
  logic            enable_reg;

  logic [7:0]      mask;
  logic [7:0]      masked_data;
  logic            bit_end;
  logic [2:0]      last_idx;
  logic            unused_bits;

  assign unused_bits = ^tx_data_i[31:8];

  always_comb begin
    mask = 8'hFF;
    case (data_bit_num_i)
      2'b00:   mask = 8'h1F;
      2'b01:   mask = 8'h3F;
      2'b10:   mask = 8'h7F;
      default: mask = 8'hFF;
    endcase
  end

  assign masked_data = tx_data_i[7:0] & mask;
  assign bit_end     = tx_tick && (tick_cnt_reg == TICK_MAX);
  // Data length code 0..3 maps to last bit index 4..7.
  assign last_idx    = 3'd4 + {1'b0, data_bit_num_reg};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= TX_IDLE;
      tick_cnt_reg     <= '0;
      bit_idx_reg      <= '0;
      stop_cnt_reg     <= 1'b0;
      data_reg         <= '0;
      data_bit_num_reg <= '0;
      parity_en_reg    <= 1'b0;
      parity_reg       <= 1'b0;
      stop_bit_num_reg <= 1'b0;
      tx_reg           <= 1'b1;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      enable_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (state_reg == TX_IDLE) begin
        if (start_tx_i && !cts_n) begin
          data_reg         <= masked_data;
          data_bit_num_reg <= data_bit_num_i;
          parity_en_reg    <= parity_en_i;
          parity_reg       <= parity_type_i ? (^masked_data) : ~(^masked_data);
          stop_bit_num_reg <= stop_bit_num_i;
          tick_cnt_reg     <= '0;
          bit_idx_reg      <= '0;
          stop_cnt_reg     <= 1'b0;
          state_reg        <= TX_START;
          tx_reg           <= 1'b0;
          busy_reg         <= 1'b1;
          enable_reg       <= 1'b1;
        end
      end else if (tx_tick) begin
        tick_cnt_reg <= bit_end ? '0 : tick_cnt_reg + 1'b1;
        if (bit_end) begin
          case (state_reg)
            TX_START: begin
              state_reg   <= TX_DATA;
              bit_idx_reg <= '0;
              tx_reg      <= data_reg[0];
            end
            TX_DATA: begin
              if (bit_idx_reg == last_idx) begin
                if (parity_en_reg) begin
                  state_reg <= TX_PARITY;
                  tx_reg    <= parity_reg;
                end else begin
                  state_reg    <= TX_STOP;
                  stop_cnt_reg <= 1'b0;
                  tx_reg       <= 1'b1;
                end
              end else begin
                bit_idx_reg <= bit_idx_reg + 3'd1;
                tx_reg      <= data_reg[bit_idx_reg + 3'd1];
              end
            end
            TX_PARITY: begin
              state_reg    <= TX_STOP;
              stop_cnt_reg <= 1'b0;
              tx_reg       <= 1'b1;
            end
            TX_STOP: begin
              if (stop_cnt_reg == stop_bit_num_reg) begin
                state_reg  <= TX_IDLE;
                done_reg   <= 1'b1;
                busy_reg   <= 1'b0;
                enable_reg <= 1'b0;
              end else begin
                stop_cnt_reg <= 1'b1;
              end
            end
            default: begin
              state_reg <= TX_IDLE;
              tx_reg    <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  assign tx        = tx_reg;
  assign tx_busy_o = busy_reg;
  assign tx_done_o = done_reg;
  assign tx_enable = enable_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: each frame is checked cycle by cycle against a
// hand-written bit sequence, including done timing, flow control and reset.
module tb_uart_tx;

  logic        clk;
  logic        reset;
  logic        tx_tick;
  logic [1:0]  data_bit_num_i;
  logic        parity_en_i;
  logic        parity_type_i;
  logic        stop_bit_num_i;
  logic [31:0] tx_data_i;
  logic        start_tx_i;
  logic        cts_n;
  logic        tx;
  logic        tx_busy_o;
  logic        tx_done_o;
  logic        tx_enable;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx #(.TICKS_PER_BIT(16)) dut (
    .clk(clk), .reset(reset), .tx_tick(tx_tick),
    .data_bit_num_i(data_bit_num_i), .parity_en_i(parity_en_i),
    .parity_type_i(parity_type_i), .stop_bit_num_i(stop_bit_num_i),
    .tx_data_i(tx_data_i), .start_tx_i(start_tx_i), .cts_n(cts_n),
    .tx(tx), .tx_busy_o(tx_busy_o), .tx_done_o(tx_done_o), .tx_enable(tx_enable)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      start_tx_i = 1'b0;
      check($sformatf("%s idle tx", tag), tx, 1);
      check($sformatf("%s idle busy", tag), tx_busy_o, 0);
      check($sformatf("%s idle done", tag), tx_done_o, 0);
      check($sformatf("%s idle enable", tag), tx_enable, 0);
    end
  endtask

  // Request a frame in the current cycle (cycle 0) and follow it to its done cycle.
  // Config inputs are scrambled, cts_n toggled and start re-pulsed mid-frame.
  task automatic send(input string tag, input logic [31:0] data, input logic [1:0] nb,
                      input logic pe, input logic pt, input logic sb,
                      input int len, input logic [11:0] exp_bits, input int div);
    int b;
    b = 16 * div;
    tx_data_i      = data;
    data_bit_num_i = nb;
    parity_en_i    = pe;
    parity_type_i  = pt;
    stop_bit_num_i = sb;
    cts_n          = 1'b0;
    start_tx_i     = 1'b1;
    tx_tick        = 1'b1;
    for (int c = 1; c <= len * b + 1; c++) begin
      @(posedge clk); #1;
      if (c <= len * b) begin
        check($sformatf("%s tx c%0d", tag, c), tx, exp_bits[(c-1)/b]);
        check($sformatf("%s busy c%0d", tag, c), tx_busy_o, 1);
        check($sformatf("%s enable c%0d", tag, c), tx_enable, 1);
        check($sformatf("%s done c%0d", tag, c), tx_done_o, 0);
      end else begin
        check($sformatf("%s done c%0d", tag, c), tx_done_o, 1);
        check($sformatf("%s busy end", tag), tx_busy_o, 0);
        check($sformatf("%s enable end", tag), tx_enable, 0);
        check($sformatf("%s tx end", tag), tx, 1);
      end
      start_tx_i     = (c == 20);
      cts_n          = (c >= 3 && c <= 10);
      tx_tick        = ((c % div) == 0);
      tx_data_i      = ~data;
      data_bit_num_i = ~nb;
      parity_en_i    = ~pe;
      parity_type_i  = ~pt;
      stop_bit_num_i = ~sb;
    end
    cts_n = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    tx_tick        = 1'b0;
    data_bit_num_i = 2'b11;
    parity_en_i    = 1'b0;
    parity_type_i  = 1'b0;
    stop_bit_num_i = 1'b0;
    tx_data_i      = '0;
    start_tx_i     = 1'b0;
    cts_n          = 1'b0;
    #2;
    check("reset tx", tx, 1);
    check("reset busy", tx_busy_o, 0);
    check("reset done", tx_done_o, 0);
    check("reset enable", tx_enable, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_cycles("post_reset", 2);

    // 8N1 0xA5
    send("8n1_a5", 32'h0000_00A5, 2'b11, 1'b0, 1'b0, 1'b0, 10, {2'b0, 1'b1, 8'hA5, 1'b0}, 1);
    idle_cycles("8n1_a5", 3);

    // 7 data bits 0x35, odd then even parity, 2 stop bits
    send("7o2_35", 32'h0000_0035, 2'b10, 1'b1, 1'b0, 1'b1, 11, {1'b0, 2'b11, 1'b1, 7'h35, 1'b0}, 1);
    idle_cycles("7o2_35", 2);
    send("7e2_35", 32'h0000_0035, 2'b10, 1'b1, 1'b1, 1'b1, 11, {1'b0, 2'b11, 1'b0, 7'h35, 1'b0}, 1);
    idle_cycles("7e2_35", 2);

    // 5 data bits: only 1,1,0,0,0 from 0xFFFFFFE3
    send("5n1_e3", 32'hFFFF_FFE3, 2'b00, 1'b0, 1'b0, 1'b0, 7, {5'b0, 1'b1, 5'b00011, 1'b0}, 1);
    idle_cycles("5n1_e3", 2);

    // Flow control blocks frame start; request is not queued
    cts_n      = 1'b1;
    start_tx_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("cts_block tx %0d", i), tx, 1);
      check($sformatf("cts_block busy %0d", i), tx_busy_o, 0);
    end
    start_tx_i = 1'b0;
    cts_n      = 1'b0;
    idle_cycles("cts_release", 2);

    // Slow tick: one tick every 4 cycles
    send("div4_c3", 32'h0000_00C3, 2'b11, 1'b0, 1'b0, 1'b0, 10, {2'b0, 1'b1, 8'hC3, 1'b0}, 4);
    idle_cycles("div4_c3", 2);

    // Reset asserted during the data phase
    tx_data_i      = 32'h0000_00FF;
    data_bit_num_i = 2'b11;
    parity_en_i    = 1'b0;
    stop_bit_num_i = 1'b0;
    start_tx_i     = 1'b1;
    tx_tick        = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      start_tx_i = 1'b0;
    end
    check("mid_rst data phase tx", tx, 1);
    check("mid_rst data phase busy", tx_busy_o, 1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst async tx", tx, 1);
    check("mid_rst async busy", tx_busy_o, 0);
    check("mid_rst async enable", tx_enable, 0);
    check("mid_rst async done", tx_done_o, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_cycles("after_rst", 3);

    // 0x3C then a back-to-back 8E1 0x5A requested in the done cycle
    send("rst_3c", 32'h0000_003C, 2'b11, 1'b0, 1'b0, 1'b0, 10, {2'b0, 1'b1, 8'h3C, 1'b0}, 1);
    send("b2b_5a", 32'h0000_005A, 2'b11, 1'b1, 1'b1, 1'b0, 11, {1'b0, 1'b1, 1'b0, 8'h5A, 1'b0}, 1);
    idle_cycles("b2b_5a", 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
